// File: rtl/hazard_detect_unit.sv
// Hazard/forwarding controller for the 5-stage RV32I pipeline: load-use stall, branch flush, operand forwarding.
// Optional macro HAZARD_FORWARD_EN enables forwarding; when undefined, dependencies are resolved by stalling.
module hazard_detect_unit #(
   parameter int unsigned REG_ADDR_W = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [REG_ADDR_W-1:0] rs1_ID,
   input  logic [REG_ADDR_W-1:0] rs2_ID,
   input  logic [REG_ADDR_W-1:0] rd_ID,
   input  logic                  rs1use_ID,
   input  logic                  rs2use_ID,
   input  logic [1:0]            hazard_optype_ID,
   input  logic                  Branch_ID,
   output logic                  PC_EN_IF,
   output logic                  reg_FD_EN,
   output logic                  reg_FD_flush,
   output logic                  reg_DE_flush,
   output logic [1:0]            forward_ctrl_A,
   output logic [1:0]            forward_ctrl_B,
   output logic                  forward_ctrl_ls
);

   localparam int unsigned OP_W     = 2;
   localparam logic [OP_W-1:0] OP_NONE  = 2'b00;
   localparam logic [OP_W-1:0] OP_ALU   = 2'b01;
   localparam logic [OP_W-1:0] OP_LOAD  = 2'b10;
   localparam logic [OP_W-1:0] OP_STORE = 2'b11;

   logic [OP_W-1:0]       r_optype_ex;
   logic [REG_ADDR_W-1:0] r_rd_ex;
   logic [OP_W-1:0]       r_optype_mem;
   logic [REG_ADDR_W-1:0] r_rd_mem;

   logic w_m1ex, w_m2ex, w_m1mem, w_m2mem;
   logic w_hazard, w_stall;

   assign w_m1ex  = rs1use_ID & (r_rd_ex  != '0) & (rs1_ID == r_rd_ex);
   assign w_m2ex  = rs2use_ID & (r_rd_ex  != '0) & (rs2_ID == r_rd_ex);
   assign w_m1mem = rs1use_ID & (r_rd_mem != '0) & (rs1_ID == r_rd_mem);
   assign w_m2mem = rs2use_ID & (r_rd_mem != '0) & (rs2_ID == r_rd_mem);

`ifdef HAZARD_FORWARD_EN
   logic [REG_ADDR_W-1:0] r_rs2_ex;
   logic [1:0]            w_fwd_a, w_fwd_b;
   logic                  w_fwd_ls;

   // EX ALU result beats MEM; stores never forward
   function automatic logic [1:0] f_fwd(input logic i_mex, input logic i_mmem,
                                        input logic [OP_W-1:0] i_op_ex,
                                        input logic [OP_W-1:0] i_op_mem);
      logic [1:0] v_sel;
      v_sel = 2'b00;
      if (i_mex && i_op_ex == OP_ALU)          v_sel = 2'b01;
      else if (i_mmem && i_op_mem == OP_ALU)   v_sel = 2'b10;
      else if (i_mmem && i_op_mem == OP_LOAD)  v_sel = 2'b11;
      return v_sel;
   endfunction

   assign w_hazard = (r_optype_ex == OP_LOAD) &
                     (w_m1ex | (w_m2ex & (hazard_optype_ID != OP_STORE)));
   assign w_fwd_a  = f_fwd(w_m1ex, w_m1mem, r_optype_ex, r_optype_mem);
   assign w_fwd_b  = f_fwd(w_m2ex, w_m2mem, r_optype_ex, r_optype_mem);
   assign w_fwd_ls = (r_optype_ex == OP_STORE) & (r_optype_mem == OP_LOAD) &
                     (r_rd_mem != '0) & (r_rd_mem == r_rs2_ex);

   always_ff @(posedge clk) begin
      if (rst)          r_rs2_ex <= '0;
      else if (w_stall) r_rs2_ex <= '0;
      else              r_rs2_ex <= rs2_ID;
   end
`else
   logic w_prod_ex, w_prod_mem;

   // Without forwarding, wait until any ALU/load producer reaches WB
   assign w_prod_ex  = (r_optype_ex  == OP_ALU) | (r_optype_ex  == OP_LOAD);
   assign w_prod_mem = (r_optype_mem == OP_ALU) | (r_optype_mem == OP_LOAD);
   assign w_hazard   = (w_prod_ex  & (w_m1ex  | w_m2ex)) |
                       (w_prod_mem & (w_m1mem | w_m2mem));
`endif

   assign w_stall = w_hazard & ~rst;

   // EX/MEM shadow slots; a stall pushes a bubble into EX
   always_ff @(posedge clk) begin
      if (rst) begin
         r_optype_ex  <= OP_NONE;
         r_rd_ex      <= '0;
         r_optype_mem <= OP_NONE;
         r_rd_mem     <= '0;
      end else begin
         r_optype_mem <= r_optype_ex;
         r_rd_mem     <= r_rd_ex;
         if (w_stall) begin
            r_optype_ex <= OP_NONE;
            r_rd_ex     <= '0;
         end else begin
            r_optype_ex <= hazard_optype_ID;
            r_rd_ex     <= rd_ID;
         end
      end
   end

   always_comb begin
      PC_EN_IF        = 1'b1;
      reg_FD_EN       = 1'b1;
      reg_FD_flush    = 1'b0;
      reg_DE_flush    = 1'b0;
      forward_ctrl_A  = 2'b00;
      forward_ctrl_B  = 2'b00;
      forward_ctrl_ls = 1'b0;
      if (!rst) begin
         PC_EN_IF     = ~w_stall;
         reg_FD_EN    = ~w_stall;
         reg_DE_flush = w_stall;
         // a stalled branch sees stale operands, so it must not flush yet
         reg_FD_flush = Branch_ID & ~w_stall;
`ifdef HAZARD_FORWARD_EN
         forward_ctrl_A  = w_fwd_a;
         forward_ctrl_B  = w_fwd_b;
         forward_ctrl_ls = w_fwd_ls;
`endif
      end
   end

endmodule

// File: tb/tb_hazard_detect_unit.sv
// Scoreboard bench for hazard_detect_unit: directed pipeline scenarios plus randomized instruction streams.
module tb_hazard_detect_unit;

   localparam int unsigned AW = 5;

   logic          clk = 1'b0;
   logic          rst;
   logic [AW-1:0] rs1_ID, rs2_ID, rd_ID;
   logic          rs1use_ID, rs2use_ID;
   logic [1:0]    hazard_optype_ID;
   logic          Branch_ID;
   logic          PC_EN_IF, reg_FD_EN, reg_FD_flush, reg_DE_flush;
   logic [1:0]    forward_ctrl_A, forward_ctrl_B;
   logic          forward_ctrl_ls;

   hazard_detect_unit #(.REG_ADDR_W(AW)) dut (
      .clk(clk), .rst(rst),
      .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .rd_ID(rd_ID),
      .rs1use_ID(rs1use_ID), .rs2use_ID(rs2use_ID),
      .hazard_optype_ID(hazard_optype_ID), .Branch_ID(Branch_ID),
      .PC_EN_IF(PC_EN_IF), .reg_FD_EN(reg_FD_EN),
      .reg_FD_flush(reg_FD_flush), .reg_DE_flush(reg_DE_flush),
      .forward_ctrl_A(forward_ctrl_A), .forward_ctrl_B(forward_ctrl_B),
      .forward_ctrl_ls(forward_ctrl_ls)
   );

   always #5 clk = ~clk;

   // Instruction in flight: 0 none, 1 ALU, 2 load, 3 store
   typedef struct {
      int op;
      int rd;
      int rs2;
   } instr_t;

   instr_t     pipe[2];     // [0] = EX, [1] = MEM
   logic [8:0] exp_q[$];
   int         checks   = 0;
   int         failures = 0;
   bit         last_stall;

   function automatic bit reads(instr_t s, bit use_f, int rs);
      return use_f && s.rd != 0 && s.rd == rs;
   endfunction

   function automatic int pick_src(bit use_f, int rs);
      if (reads(pipe[0], use_f, rs) && pipe[0].op == 1) return 1;
      if (reads(pipe[1], use_f, rs) && pipe[1].op == 1) return 2;
      if (reads(pipe[1], use_f, rs) && pipe[1].op == 2) return 3;
      return 0;
   endfunction

   // Packed as {PC_EN, FD_EN, FD_flush, DE_flush, fwdA, fwdB, fwd_ls}
   function automatic logic [8:0] predict(output bit stall);
      int a1 = int'(rs1_ID);
      int a2 = int'(rs2_ID);
      int fa = 0, fb = 0;
      bit ls = 0;
      stall = 0;
`ifdef HAZARD_FORWARD_EN
      stall = pipe[0].op == 2 && (reads(pipe[0], rs1use_ID, a1) ||
              (reads(pipe[0], rs2use_ID, a2) && hazard_optype_ID != 2'd3));
      fa = pick_src(rs1use_ID, a1);
      fb = pick_src(rs2use_ID, a2);
      ls = pipe[0].op == 3 && pipe[1].op == 2 && pipe[1].rd != 0 && pipe[1].rd == pipe[0].rs2;
`else
      for (int s = 0; s < 2; s++)
         if ((pipe[s].op == 1 || pipe[s].op == 2) &&
             (reads(pipe[s], rs1use_ID, a1) || reads(pipe[s], rs2use_ID, a2)))
            stall = 1;
`endif
      if (rst) begin
         stall = 0;
         return 9'b1_1_0_0_00_00_0;
      end
      return {~stall, ~stall, Branch_ID & ~stall, stall, 2'(fa), 2'(fb), ls};
   endfunction

   // Present one ID instruction for one clock and advance the model
   task automatic cycle(input bit r, input int a1, input int a2, input int d,
                        input bit u1, input bit u2, input int op, input bit br);
      bit st;
      rst = r; rs1_ID = AW'(a1); rs2_ID = AW'(a2); rd_ID = AW'(d);
      rs1use_ID = u1; rs2use_ID = u2; hazard_optype_ID = 2'(op); Branch_ID = br;
      exp_q.push_back(predict(st));
      last_stall = st;
      @(posedge clk);
      if (r) begin
         pipe[0] = '{0, 0, 0};
         pipe[1] = '{0, 0, 0};
      end else begin
         pipe[1] = pipe[0];
         pipe[0] = st ? instr_t'{0, 0, 0} : instr_t'{op, d, a2};
      end
      #1;
   endtask

   // Hold the instruction in ID while the pipeline stalls it
   task automatic issue(input int a1, input int a2, input int d,
                        input bit u1, input bit u2, input int op, input bit br);
      int n = 0;
      do begin
         cycle(1'b0, a1, a2, d, u1, u2, op, br);
         n++;
      end while (last_stall && n < 4);
   endtask

   task automatic nop();
      issue(0, 0, 0, 0, 0, 0, 0);
   endtask

   // Monitor: outputs are valid every cycle; compare mid-cycle
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         logic [8:0] e, a;
         e = exp_q.pop_front();
         a = {PC_EN_IF, reg_FD_EN, reg_FD_flush, reg_DE_flush,
              forward_ctrl_A, forward_ctrl_B, forward_ctrl_ls};
         checks++;
         if (a !== e) begin
            failures++;
            $display("FAIL outs t=%0t got=%b exp=%b (pc,fd,fdfl,defl,fa,fb,ls)", $time, a, e);
         end
      end
   end

   initial begin
      pipe[0] = '{0, 0, 0};
      pipe[1] = '{0, 0, 0};
      last_stall = 0;
      rst = 1'b1; rs1_ID = '0; rs2_ID = '0; rd_ID = '0;
      rs1use_ID = 0; rs2use_ID = 0; hazard_optype_ID = 2'd0; Branch_ID = 0;
      @(posedge clk); #1;
      cycle(1, 0, 0, 0, 0, 0, 0, 0);
      cycle(1, 5, 5, 5, 1, 1, 1, 1);

      // ALU -> ALU, then with a bubble between
      issue(1, 2, 5, 1, 1, 1, 0);
      issue(5, 1, 6, 1, 1, 1, 0);
      issue(1, 2, 5, 1, 1, 1, 0);
      nop();
      issue(5, 1, 6, 1, 1, 1, 0);
      nop(); nop();

      // Load-use into a taken branch (also branch-during-stall)
      issue(2, 0, 7, 1, 0, 2, 0);
      issue(7, 0, 0, 1, 1, 0, 1);
      nop(); nop();

      // Load -> store data
      issue(2, 0, 8, 1, 0, 2, 0);
      issue(2, 8, 0, 1, 1, 3, 0);
      nop(); nop(); nop();

      // x0 producer
      issue(0, 0, 0, 1, 0, 1, 0);
      issue(0, 0, 1, 1, 1, 1, 0);
      nop(); nop();

      // Reset in the middle of a load-use stall
      issue(2, 0, 7, 1, 0, 2, 0);
      cycle(1, 7, 0, 0, 1, 1, 0, 1);
      issue(7, 0, 0, 1, 1, 0, 1);
      nop(); nop();

      // Randomized streams over a small register set to force collisions
      for (int i = 0; i < 3000; i++) begin
         bit r = ($urandom_range(0, 49) == 0);
         if (!last_stall || r)
            cycle(r, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
                  int'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0));
         else
            cycle(0, int'(rs1_ID), int'(rs2_ID), int'(rd_ID), rs1use_ID, rs2use_ID,
                  int'(hazard_optype_ID), Branch_ID);
      end

      repeat (3) @(posedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain left=%0d exp=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
